// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: mode encoding and default width.
package counter_pkg;

  localparam logic CNT_WRAP      = 1'b0;
  localparam logic CNT_SAT       = 1'b1;
  localparam int   CNT_WIDTH_DEF = 3;

endpackage

// File: rtl/upcounter.sv
// Up-counter with clear/load/enable priority, programmable terminal value,
// wrap-or-saturate selection, terminal-count flag, wrap pulse and sticky overflow.
module upcounter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] counter_r;
  logic             wrap_r;
  logic             ovf_r;
  logic             at_limit_s;

  // A count loaded above the limit is treated like one sitting at the limit.
  assign at_limit_s = (counter_r >= limit);

  // Count state, wrap pulse and sticky overflow; priority clr > load > en > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_r <= '0;
      wrap_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (clr) begin
      counter_r <= '0;
      wrap_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (load) begin
      counter_r <= load_val;
      wrap_r    <= 1'b0;
    end else if (en) begin
      if (!at_limit_s) begin
        counter_r <= counter_r + WIDTH'(1);
        wrap_r    <= 1'b0;
      end else if (sat_mode == CNT_SAT) begin
        counter_r <= limit;
        wrap_r    <= 1'b0;
        ovf_r     <= 1'b1;
      end else begin
        counter_r <= '0;
        wrap_r    <= 1'b1;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign counter = counter_r;
  assign wrap    = wrap_r;
  assign ovf     = ovf_r;
  assign tc      = at_limit_s;

endmodule

// File: tb/tb_upcounter.sv
// Self-checking bench for upcounter (WIDTH = 3): directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
module tb_upcounter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, load, sat_mode;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] counter;
  logic         tc, wrap, ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt;
  bit m_wrap, m_ovf;

  upcounter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
    .counter(counter), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_wrap = 0; m_ovf = 0;
  endtask

  // next state from the operation rules, using plain integer arithmetic
  task automatic model_step();
    int lim;
    lim = int'(limit);
    if (clr) begin
      m_cnt = 0; m_ovf = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_wrap = 0;
    end else if (en) begin
      if (m_cnt < lim) begin
        m_cnt = m_cnt + 1; m_wrap = 0;
      end else if (sat_mode) begin
        m_cnt = lim; m_ovf = 1; m_wrap = 0;
      end else begin
        m_cnt = 0; m_wrap = 1;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; load = 0;
  endtask

  task automatic test_reset();
    rst = 0; en = 1; clr = 0; load = 0; load_val = 3'd0; limit = 3'd0; sat_mode = 1'b0;
    model_reset();
    #10;
    checks++; if (counter !== 3'd0) begin errors++; $display("FAIL rst_counter got %0d exp 0", counter); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got %b exp 0", wrap); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL rst_tc_lim0 got %b exp 1", tc); end
    limit = 3'd3; #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_tc_lim3 got %b exp 0", tc); end
    rst = 1; en = 0; limit = 3'd7;
    tick();
    // count to 5 then pull reset between edges
    en = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (counter !== 3'd5) begin errors++; $display("FAIL pre_reset_count got %0d exp 5", counter); end
    rst = 0; model_reset();
    #1;
    checks++; if (counter !== 3'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL async_reset got cnt=%0d wrap=%b ovf=%b exp 0/0/0", counter, wrap, ovf);
    end
    #1 rst = 1; idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    clr = 1; tick(); clr = 0;
    limit = 3'd7; sat_mode = 1'b0; en = 1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (counter !== 3'((i) % 8)) begin errors++; $display("FAIL wrap_seq[%0d] got %0d exp %0d", i, counter, i % 8); end
      checks++; if (tc !== (i == 7)) begin errors++; $display("FAIL wrap_tc[%0d] got %b exp %b", i, tc, (i == 7)); end
      tick();
      if (wrap) wraps++;
      checks++; if (wrap !== m_wrap || counter !== 3'(m_cnt)) begin
        errors++; $display("FAIL wrap_model[%0d] got cnt=%0d wrap=%b exp cnt=%0d wrap=%b", i, counter, wrap, m_cnt, m_wrap);
      end
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL wrap_pulses got %0d exp 1", wraps); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    clr = 1; tick(); clr = 0;
    limit = 3'd4; sat_mode = 1'b1; en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (counter !== 3'((i + 1 > 4) ? 4 : i + 1)) begin
        errors++; $display("FAIL sat_seq[%0d] got %0d exp %0d", i, counter, (i + 1 > 4) ? 4 : i + 1);
      end
      checks++; if (ovf !== (i >= 4)) begin errors++; $display("FAIL sat_ovf[%0d] got %b exp %b", i, ovf, (i >= 4)); end
    end
    en = 0; clr = 1; tick(); clr = 0;
    checks++; if (counter !== 3'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL sat_clr got cnt=%0d ovf=%b exp 0/0", counter, ovf);
    end
  endtask

  task automatic test_priority();
    limit = 3'd7; sat_mode = 1'b0;
    clr = 1; load = 1; en = 1; load_val = 3'd6;
    tick();
    checks++; if (counter !== 3'd0) begin errors++; $display("FAIL prio_clr got %0d exp 0", counter); end
    clr = 0;
    tick();
    checks++; if (counter !== 3'd6) begin errors++; $display("FAIL prio_load got %0d exp 6", counter); end
    idle_inputs();
  endtask

  task automatic test_load_above();
    limit = 3'd3; sat_mode = 1'b0; load_val = 3'd6;
    load = 1; tick(); load = 0;
    checks++; if (counter !== 3'd6 || tc !== 1'b1) begin errors++; $display("FAIL above_load got cnt=%0d tc=%b exp 6/1", counter, tc); end
    en = 1; tick(); en = 0;
    checks++; if (counter !== 3'd0 || wrap !== 1'b1) begin errors++; $display("FAIL above_wrap got cnt=%0d wrap=%b exp 0/1", counter, wrap); end
    sat_mode = 1'b1;
    load = 1; tick(); load = 0;
    checks++; if (ovf !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL above_sat_pre got ovf=%b wrap=%b exp 0/0", ovf, wrap); end
    en = 1; tick(); en = 0;
    checks++; if (counter !== 3'd3 || ovf !== 1'b1) begin errors++; $display("FAIL above_sat got cnt=%0d ovf=%b exp 3/1", counter, ovf); end
    load_val = 3'd1; load = 1; tick(); load = 0;
    checks++; if (counter !== 3'd1 || ovf !== 1'b1) begin errors++; $display("FAIL load_keeps_ovf got cnt=%0d ovf=%b exp 1/1", counter, ovf); end
    clr = 1; tick(); clr = 0;
  endtask

  task automatic test_limit_zero_hold();
    limit = 3'd0; sat_mode = 1'b0; en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (counter !== 3'd0 || wrap !== 1'b1 || tc !== 1'b1) begin
        errors++; $display("FAIL lim0_wrap[%0d] got cnt=%0d wrap=%b tc=%b exp 0/1/1", i, counter, wrap, tc);
      end
    end
    en = 0; limit = 3'd7; load_val = 3'd2; load = 1; tick(); load = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (counter !== 3'd2 || wrap !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got cnt=%0d wrap=%b exp 2/0", i, counter, wrap);
      end
    end
    limit = 3'd0; sat_mode = 1'b1; clr = 1; tick(); clr = 0;
    en = 1; tick(); en = 0;
    checks++; if (counter !== 3'd0 || ovf !== 1'b1) begin errors++; $display("FAIL lim0_sat got cnt=%0d ovf=%b exp 0/1", counter, ovf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(19, 0) == 0);
      load     = ($urandom_range(7, 0) == 0);
      en       = ($urandom_range(3, 0) != 0);
      load_val = 3'($urandom_range(7, 0));
      if ($urandom_range(15, 0) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(15, 0) == 0) limit = 3'($urandom_range(7, 0));
      tick();
      checks++;
      if (counter !== 3'(m_cnt) || wrap !== m_wrap || ovf !== m_ovf || tc !== (m_cnt >= int'(limit))) begin
        errors++;
        $display("FAIL rand[%0d] got cnt=%0d wrap=%b ovf=%b tc=%b exp cnt=%0d wrap=%b ovf=%b tc=%b",
                 i, counter, wrap, ovf, tc, m_cnt, m_wrap, m_ovf, (m_cnt >= int'(limit)));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_load_above();
    test_limit_zero_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
